cordic_gain_comp_buffer: RTL
============================

Name: cordic_gain_comp_buffer

Overview:
- Sits directly downstream of the pipelined rotation CORDIC.
- Removes the CORDIC gain K ≈ 1.6467603 by multiplying x/y by 1/K, with rounding and saturation, and passes code through alongside.
- Holds results in a small show-ahead FIFO with a valid/ready output handshake, because the CORDIC pipeline itself cannot stall.
- Reports any sample dropped on overflow.

Parameters:
- WIDTH, 16: bit width of x/y; signed, same fixed-point format as the CORDIC outputs.
- FRAC_BITS, 12: fractional bits of x/y; informational only, since the format is unchanged through the block.
- CODE_WIDTH, 8: width of the pass-through code.
- GAIN_INV, 39797: unsigned Q1.16 scale constant, 17 bits max; default = round(65536/K).
- DEPTH, 4: FIFO entries; power of 2, ≥ 2.

Ports:
- clock  in  1  single clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high; sampled on the rising edge of clock.
- x_in  in  WIDTH  signed CORDIC x result.
- y_in  in  WIDTH  signed CORDIC y result.
- code_in  in  CODE_WIDTH  pass-through tag.
- valid_in  in  1  x_in/y_in/code_in valid this cycle; there is no backpressure upstream.
- x_out  out  WIDTH  gain-compensated x at the FIFO head.
- y_out  out  WIDTH  gain-compensated y at the FIFO head.
- code_out  out  CODE_WIDTH  tag at the FIFO head.
- valid_out  out  1  FIFO non-empty.
- ready_in  in  1  downstream accepts the head this cycle.
- count  out  $clog2(DEPTH+1)  current FIFO occupancy.
- overflow  out  1  one-cycle pulse per dropped sample.

Behaviour:
- Reset: on a clock edge with reset=1, all stage registers, FIFO pointers, count and overflow clear to 0. x_out/y_out/code_out/valid_out read 0. Reset overrides any in-flight samples, which are discarded. The first sample accepted is the one on the first edge with reset=0.
- Stage 1, edge E: capture valid/code. Products px = x_in * {0,GAIN_INV} and py = y_in * {0,GAIN_INV}, each signed, width WIDTH+18.
- Stage 2, edge E+1: rounding is round-half-up, r = (p + 2^15) >>> 16 (arithmetic shift). r is saturated to [-2^(WIDTH-1), 2^(WIDTH-1)-1]. Saturation cannot occur with the default GAIN_INV but is required for general GAIN_INV.
- FIFO write, edge E+2: the stage-2 sample is written if valid. First-word latency: a sample sampled at edge E appears on the outputs, valid_out=1, after edge E+2 when the FIFO was empty. There is no combinational bypass.
- Pop: when valid_out && ready_in at an edge, the head advances. ready_in is ignored while valid_out=0. Head outputs are stable while valid_out=1 && ready_in=0.
- Simultaneous write and pop:
  - FIFO full: the write is accepted and count is unchanged.
  - FIFO empty: impossible, because pop requires valid_out.
- Write when full with no pop: the sample is dropped and FIFO contents are unchanged. overflow=1 for exactly the following cycle; back-to-back drops give continuous pulses.
- Pointers wrap modulo DEPTH. count is in range 0..DEPTH. Ordering is strictly FIFO.
- code is carried unmodified through both stages and the FIFO, aligned with its x/y.
- Stage registers advance every cycle regardless of FIFO state; there is no stall.

Test Plan:
- Scaling: x_in=4096, y_in=-4096, code=0x5A, one valid pulse, ready_in=1 → 3 edges later, one cycle of valid_out with x_out=2487, y_out=-2487, code_out=0x5A, count=1.
- Gain cancel, extremes: x_in=6745 → x_out=4096. x_in=-32768 → -19898. x_in=32767 → 19898. x_in=0 → 0.
- Streaming: 20 consecutive valids with x_in=i*100, code=i, ready_in=1 → outputs in order with a 3-edge lag, count never exceeds 1, overflow never asserts.
- Backpressure/overflow: DEPTH=4, ready_in=0, 6 back-to-back valids with codes 1..6:
  - count saturates at 4, overflow pulses for 2 cycles, codes 5 and 6 are lost.
  - Then ready_in=1 → codes 1,2,3,4 drain one per cycle, valid_out falls after the 4th.
- Full plus simultaneous pop: FIFO full, ready_in=1, new valid arrives → no overflow, count stays 4, new entry appears last in order.
- Reset mid-operation: 3 samples in flight plus 2 stored, assert reset for 1 cycle → after that edge valid_out=0, count=0, overflow=0. No pre-reset sample ever emerges. A sample after reset emerges 3 edges later with the correct value.

Source files
------------

// File: rtl/cordic_gain_comp_buffer.sv
// Removes the rotation-CORDIC gain from x/y (Q1.16 multiply, round-half-up, saturate)
// and buffers results with their code in a show-ahead FIFO behind a valid/ready port.
module cordic_gain_comp_buffer #(
  parameter int WIDTH      = 16,
  parameter int FRAC_BITS  = 12,
  parameter int CODE_WIDTH = 8,
  parameter int GAIN_INV   = 39797,
  parameter int DEPTH      = 4
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [WIDTH-1:0]             x_in,
  input  logic [WIDTH-1:0]             y_in,
  input  logic [CODE_WIDTH-1:0]        code_in,
  input  logic                         valid_in,
  output logic [WIDTH-1:0]             x_out,
  output logic [WIDTH-1:0]             y_out,
  output logic [CODE_WIDTH-1:0]        code_out,
  output logic                         valid_out,
  input  logic                         ready_in,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         overflow
);

  localparam int PW = WIDTH + 18;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic signed [PW-1:0] GAIN  = PW'(GAIN_INV);
  localparam logic signed [PW-1:0] ROUND = PW'(32768);

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0) || (FRAC_BITS >= WIDTH)) begin : gBadParams
    $error("cordic_gain_comp_buffer: illegal parameter combination");
  end

  // Result is saturated whenever the bits above the output sign bit disagree with it.
  function automatic logic [WIDTH-1:0] roundSat(input logic signed [PW-1:0] p);
    logic signed [PW-1:0] r;
    r = (p + ROUND) >>> 16;
    if ((r[PW-1:WIDTH-1] == {(PW-WIDTH+1){1'b0}}) || (r[PW-1:WIDTH-1] == {(PW-WIDTH+1){1'b1}}))
      return r[WIDTH-1:0];
    else if (r[PW-1])
      return {1'b1, {(WIDTH-1){1'b0}}};
    else
      return {1'b0, {(WIDTH-1){1'b1}}};
  endfunction

  logic                   s1Valid_q, s2Valid_q;
  logic [CODE_WIDTH-1:0]  s1Code_q, s2Code_q;
  logic signed [PW-1:0]   s1X_q, s1Y_q;
  logic [WIDTH-1:0]       s2X_q, s2Y_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      s1Valid_q <= 1'b0;
      s1Code_q  <= '0;
      s1X_q     <= '0;
      s1Y_q     <= '0;
      s2Valid_q <= 1'b0;
      s2Code_q  <= '0;
      s2X_q     <= '0;
      s2Y_q     <= '0;
    end else begin
      s1Valid_q <= valid_in;
      s1Code_q  <= code_in;
      s1X_q     <= PW'($signed(x_in)) * GAIN;
      s1Y_q     <= PW'($signed(y_in)) * GAIN;
      s2Valid_q <= s1Valid_q;
      s2Code_q  <= s1Code_q;
      s2X_q     <= roundSat(s1X_q);
      s2Y_q     <= roundSat(s1Y_q);
    end
  end

  logic [WIDTH-1:0]      memX_q    [DEPTH];
  logic [WIDTH-1:0]      memY_q    [DEPTH];
  logic [CODE_WIDTH-1:0] memCode_q [DEPTH];
  logic [AW-1:0]         wrPtr_q, rdPtr_q;
  logic [CW-1:0]         count_q, count_d;
  logic                  overflow_q;
  logic                  full, pop, wrEn;

  assign valid_out = (count_q != '0);
  assign full      = (count_q == CW'(DEPTH));
  assign pop       = valid_out && ready_in;
  // A pop in the same edge frees the slot, so a full FIFO can still take the write.
  assign wrEn      = s2Valid_q && (!full || pop);

  always_comb begin
    count_d = count_q;
    if (wrEn && !pop)
      count_d = count_q + CW'(1);
    else if (!wrEn && pop)
      count_d = count_q - CW'(1);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (wrEn) wrPtr_q <= wrPtr_q + AW'(1);
      if (pop)  rdPtr_q <= rdPtr_q + AW'(1);
      count_q    <= count_d;
      overflow_q <= s2Valid_q && !wrEn;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset && wrEn) begin
      memX_q[wrPtr_q]    <= s2X_q;
      memY_q[wrPtr_q]    <= s2Y_q;
      memCode_q[wrPtr_q] <= s2Code_q;
    end
  end

  assign x_out    = valid_out ? memX_q[rdPtr_q]    : '0;
  assign y_out    = valid_out ? memY_q[rdPtr_q]    : '0;
  assign code_out = valid_out ? memCode_q[rdPtr_q] : '0;
  assign count    = count_q;
  assign overflow = overflow_q;

endmodule
